// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer
// Owns the fetch PC, keeps up to DEPTH in-order imem requests in flight and
// buffers returned words in a DEPTH-entry FIFO that feeds decode through a
// valid/ready handshake. A redirect flushes the FIFO, marks every request
// still in flight as stale (to be discarded on return) and restarts fetch.
module fetch_prefetch_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   occ_reg, occ_next;
  logic [CW-1:0]   outst_reg, outst_next;
  logic [CW-1:0]   disc_reg, disc_next;

  // FIFO payload storage (no reset needed: outputs are masked by occupancy)
  logic [XLEN-1:0] fifo_pc_mem    [DEPTH];
  logic [XLEN-1:0] fifo_instr_mem [DEPTH];
  logic [DEPTH-1:0] entry_wr_en;

  // Handshake qualifiers
  logic [CW:0]     credit_sum;
  logic            grant;
  logic            resp_ok;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

  // Issue credit, handshake decode and decode-side outputs
  always_comb begin
    credit_sum      = {1'b0, occ_reg} + {1'b0, outst_reg};
    imem_req_o      = !reset && !redirect_i && (credit_sum < DEPTH_SUM);
    imem_addr_o     = fetch_pc_reg & WORD_MASK;
    redirect_target = redirect_pc_i & WORD_MASK;
    grant           = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is illegal and simply ignored.
    resp_ok         = imem_rvalid_i && (outst_reg != '0);
    resp_drop       = resp_ok && (disc_reg != '0);
    push            = resp_ok && (disc_reg == '0) && !redirect_i;
    instr_valid_o   = (occ_reg != '0) && !redirect_i;
    pop             = instr_valid_o && instr_ready_i;
    instr_o         = instr_valid_o ? fifo_instr_mem[rd_ptr_reg] : '0;
    instr_pc_o      = instr_valid_o ? fifo_pc_mem[rd_ptr_reg] : '0;
  end

  // Next-state: redirect wins over everything else in the cycle
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    occ_next      = occ_reg;
    outst_next    = outst_reg;
    disc_next     = disc_reg;
    if (redirect_i) begin
      // Every request still in flight after this edge returns stale data.
      fetch_pc_next = redirect_target;
      resp_pc_next  = redirect_target;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      occ_next      = '0;
      outst_next    = outst_reg - CW'(resp_ok);
      disc_next     = outst_reg - CW'(resp_ok);
    end else begin
      if (grant) begin
        fetch_pc_next = fetch_pc_reg + PC_STEP;
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + PC_STEP;
        wr_ptr_next  = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      if (resp_drop) begin
        disc_next = disc_reg - CW'(1);
      end
      outst_next = outst_reg + CW'(grant) - CW'(resp_ok);
      occ_next   = occ_reg + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      occ_reg      <= '0;
      outst_reg    <= '0;
      disc_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      occ_reg      <= occ_next;
      outst_reg    <= outst_next;
      disc_reg     <= disc_next;
    end
  end

  // Per-entry write enables for the payload storage
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Payload write: the response word tagged with the PC it was fetched from
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_wr_en[i]) begin
        fifo_pc_mem[i]    <= resp_pc_reg;
        fifo_instr_mem[i] <= imem_rdata_i;
      end
    end
  end

  // Memory must never return a word that was not requested
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) !(imem_rvalid_i && (outst_reg == '0))
  );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Testbench for fetch_prefetch_buffer: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_prefetch_buffer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int   NVEC = 15;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int checks = 0;
  int errors = 0;

  fetch_prefetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] pc, instr; } ent_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic rdr, input logic [31:0] rpc,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] dw(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    instr_ready_i = rdy;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
  endtask

  // Two reset cycles, then check the reset values and release
  task automatic do_reset();
    reset = 1'b1;
    drive(L, L, 32'h0, L, L, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Random-run reference model state
  req_t        mem_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_fetch;
  int          epoch;

  initial begin
    int grants;
    logic prev;
    reset = 1'b1;
    drive(L, L, 32'h0, L, L, 32'h0);

    // Directed table: latency, streaming, stall, redirect with same-cycle response
    tbl[0]  = mk(H, L, 32'h0, H, L, 32'h0, H, 32'h00, L, 32'h0,   32'h0);
    tbl[1]  = mk(H, H, dw(0), H, L, 32'h0, H, 32'h04, L, 32'h0,   32'h0);
    tbl[2]  = mk(H, H, dw(1), H, L, 32'h0, H, 32'h08, H, 32'h0,   dw(0));
    tbl[3]  = mk(H, H, dw(2), H, L, 32'h0, H, 32'h0C, H, 32'h4,   dw(1));
    tbl[4]  = mk(L, H, dw(3), H, L, 32'h0, H, 32'h10, H, 32'h8,   dw(2));
    tbl[5]  = mk(L, L, 32'h0, H, L, 32'h0, H, 32'h10, H, 32'hC,   dw(3));
    tbl[6]  = mk(L, L, 32'h0, H, L, 32'h0, H, 32'h10, L, 32'h0,   32'h0);
    tbl[7]  = mk(H, L, 32'h0, L, L, 32'h0, H, 32'h10, L, 32'h0,   32'h0);
    tbl[8]  = mk(H, L, 32'h0, L, L, 32'h0, H, 32'h14, L, 32'h0,   32'h0);
    tbl[9]  = mk(H, H, dw(4), L, L, 32'h0, H, 32'h18, L, 32'h0,   32'h0);
    tbl[10] = mk(H, H, dw(5), H, H, 32'h203, L, 32'h1C, L, 32'h0, 32'h0);
    tbl[11] = mk(H, H, dw(6), H, L, 32'h0, H, 32'h200, L, 32'h0,  32'h0);
    tbl[12] = mk(L, H, dw(7), H, L, 32'h0, H, 32'h204, L, 32'h0,  32'h0);
    tbl[13] = mk(L, L, 32'h0, H, L, 32'h0, H, 32'h204, H, 32'h200, dw(7));
    tbl[14] = mk(L, L, 32'h0, H, L, 32'h0, H, 32'h204, L, 32'h0,  32'h0);

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      #1;
      $display("vec %0d: req=%b addr=%h valid=%b pc=%h instr=%h",
               i, imem_req_o, imem_addr_o, instr_valid_o, instr_pc_o, instr_o);
      chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_pc", i), instr_pc_o, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instr_o, tbl[i].e_instr);
      step();
    end

    // Credit limit: ready low, responses one cycle after each grant
    do_reset();
    grants = 0;
    prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(H, prev, dw(100 + c), L, L, 32'h0);
      #1;
      if (imem_req_o) grants++;
      prev = imem_req_o;
      step();
    end
    chk("full_grants", 32'(grants), 32'd4);
    $display("credit: %0d grants with decode stalled", grants);
    drive(H, L, 32'h0, H, L, 32'h0);
    #1;
    chk("full_req", 32'(imem_req_o), 32'h0);
    chk("full_head_pc", instr_pc_o, 32'h0);
    step();
    drive(H, L, 32'h0, L, L, 32'h0);
    #1;
    chk("reopen_req", 32'(imem_req_o), 32'h1);
    chk("reopen_addr", imem_addr_o, 32'h10);
    step();
    drive(H, H, dw(200), L, L, 32'h0);
    #1;
    chk("reclose_req", 32'(imem_req_o), 32'h0);
    step();
    drive(H, L, 32'h0, L, L, 32'h0);
    #1;
    chk("reclose_req2", 32'(imem_req_o), 32'h0);
    chk("reclose_head", instr_pc_o, 32'h4);
    step();

    // Redirect with three requests outstanding: stale responses never reach decode
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(H, L, 32'h0, H, L, 32'h0);
      #1;
      chk("stale_issue", imem_addr_o, 32'(4 * c));
      step();
    end
    drive(H, L, 32'h0, H, H, 32'h100);
    #1;
    chk("stale_redir_req", 32'(imem_req_o), 32'h0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(L, H, dw(300 + c), H, L, 32'h0);
      #1;
      chk("stale_valid", 32'(instr_valid_o), 32'h0);
      chk("stale_addr", imem_addr_o, 32'h100);
      step();
    end
    drive(H, L, 32'h0, H, L, 32'h0);
    #1;
    chk("stale_valid2", 32'(instr_valid_o), 32'h0);
    chk("target_req", 32'(imem_req_o), 32'h1);
    step();
    drive(L, H, 32'hCAFE_F00D, H, L, 32'h0);
    #1;
    chk("target_nobypass", 32'(instr_valid_o), 32'h0);
    step();
    drive(L, L, 32'h0, H, L, 32'h0);
    #1;
    $display("redirect: first pc=%h instr=%h", instr_pc_o, instr_o);
    chk("target_valid", 32'(instr_valid_o), 32'h1);
    chk("target_pc", instr_pc_o, 32'h100);
    chk("target_instr", instr_o, 32'hCAFE_F00D);
    step();

    // Grant stall holds the address; redirect during the stall retargets it
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(L, L, 32'h0, H, L, 32'h0);
      #1;
      chk("stall_req", 32'(imem_req_o), 32'h1);
      chk("stall_addr", imem_addr_o, 32'h0);
      step();
    end
    drive(L, L, 32'h0, H, H, 32'h42);
    #1;
    chk("stall_redir_req", 32'(imem_req_o), 32'h0);
    step();
    drive(L, L, 32'h0, H, L, 32'h0);
    #1;
    chk("stall_new_req", 32'(imem_req_o), 32'h1);
    chk("stall_new_addr", imem_addr_o, 32'h40);
    step();

    // Reset with two outstanding; late responses during reset are ignored
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(H, L, 32'h0, H, L, 32'h0);
      step();
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(L, H, dw(600 + c), H, L, 32'h0);
      #1;
      chk("mid_rst_req", 32'(imem_req_o), 32'h0);
      if (c > 0) chk("mid_rst_valid", 32'(instr_valid_o), 32'h0);
      step();
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(L, L, 32'h0, H, L, 32'h0);
      #1;
      chk("post_rst_req", 32'(imem_req_o), 32'h1);
      chk("post_rst_addr", imem_addr_o, 32'h0);
      chk("post_rst_valid", 32'(instr_valid_o), 32'h0);
      step();
    end
    drive(H, L, 32'h0, H, L, 32'h0);
    step();
    drive(L, H, 32'hBEEF_0001, H, L, 32'h0);
    step();
    drive(L, L, 32'h0, H, L, 32'h0);
    #1;
    chk("post_rst_pc", instr_pc_o, 32'h0);
    chk("post_rst_instr", instr_o, 32'hBEEF_0001);
    step();

    // Randomized run against the reference model
    do_reset();
    mem_q.delete();
    fifo_q.delete();
    m_fetch = 32'h0;
    epoch = 0;
    for (int c = 0; c < 4000; c++) begin
      logic g, rv, rdy, rdr, e_req, e_valid;
      logic [31:0] rd, rpc, e_pc, e_instr;
      req_t r;
      g   = ($urandom_range(0, 3) != 0);
      rv  = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rd  = rv ? mem_word(mem_q[0].addr) : $urandom;
      rdy = ((c % 200) < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 24) == 0);
      rpc = $urandom;
      drive(g, rv, rd, rdy, rdr, rpc);
      #1;
      e_req   = !rdr && ((fifo_q.size() + mem_q.size()) < 4);
      e_valid = (fifo_q.size() != 0) && !rdr;
      e_pc    = e_valid ? fifo_q[0].pc : 32'h0;
      e_instr = e_valid ? fifo_q[0].instr : 32'h0;
      chk("rnd_req", 32'(imem_req_o), 32'(e_req));
      chk("rnd_addr", imem_addr_o, m_fetch);
      chk("rnd_valid", 32'(instr_valid_o), 32'(e_valid));
      chk("rnd_pc", instr_pc_o, e_pc);
      chk("rnd_instr", instr_o, e_instr);
      if (e_valid && rdy) $display("pop cycle %0d: pc=%h instr=%h", c, e_pc, e_instr);
      if (rdr) begin
        fifo_q.delete();
        if (rv) r = mem_q.pop_front();
        epoch++;
        m_fetch = rpc & ~32'h3;
      end else begin
        if (e_valid && rdy) void'(fifo_q.pop_front());
        if (rv) begin
          r = mem_q.pop_front();
          if (r.epoch == epoch) fifo_q.push_back('{r.addr, rd});
        end
        if (e_req && g) begin
          mem_q.push_back('{m_fetch, epoch});
          m_fetch = m_fetch + 32'h4;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
